arbitro_saida_serial: RTL and testbench

ARBITRO_SAIDA_SERIAL -- requirements
Module: arbitro_saida_serial

---
 rtl/arbitro_saida_serial_pkg.sv | 41 ++++
 rtl/arbitro_saida_serial_if.sv | 33 +++
 rtl/arbitro_saida_serial_bcd_ascii.sv | 22 ++
 rtl/arbitro_saida_serial.sv | 169 ++++++++++++++++
 tb/tb_arbitro_saida_serial.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_saida_serial_pkg.sv
// -----------------------------------------------------------------------------
// arbitro_saida_serial_pkg
// Shared definitions for the serial output arbiter.
//   - estado_t       : FSM state encoding (also shown on the debug display)
//   - ASCII_*        : characters used to build each message
//   - TAM_MENSAGEM   : characters per message (ID, three digits, separator)
//   - codigo_estado  : maps a state to its 4-bit debug code (4'hF if unused)
// -----------------------------------------------------------------------------
package arbitro_saida_serial_pkg;

    typedef enum logic [2:0] {
        ESPERA    = 3'd0,
        CARREGA   = 3'd1,
        TRANSMITE = 3'd2,
        ESPERA_TX = 3'd3,
        PROXIMO   = 3'd4,
        FIM       = 3'd5
    } estado_t;

    localparam logic [6:0] ASCII_A            = 7'h41;
    localparam logic [6:0] ASCII_B            = 7'h42;
    localparam logic [6:0] ASCII_ZERO         = 7'h30;
    localparam logic [6:0] ASCII_INTERROGACAO = 7'h3F;

    localparam int         TAM_MENSAGEM  = 5;
    localparam logic [2:0] INDICE_ULTIMO = 3'(TAM_MENSAGEM - 1);

    // Channel identity as stored in the latched-ID and last-served flags.
    localparam logic CANAL_A = 1'b0;
    localparam logic CANAL_B = 1'b1;

    function automatic logic [3:0] codigo_estado(input estado_t estado);
        case (estado)
            ESPERA, CARREGA, TRANSMITE, ESPERA_TX, PROXIMO, FIM:
                codigo_estado = {1'b0, estado};
            default:
                codigo_estado = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/arbitro_saida_serial_if.sv
// -----------------------------------------------------------------------------
// arbitro_saida_serial_if
// Request and transmitter handshake bundle of the serial output arbiter.
//   pedido_a/b, dados_a/b : level requests and 12-bit BCD payloads
//   tx_pronto             : transmitter "character sent" pulse
//   tx_partida, tx_dados  : start pulse and character to the transmitter
//   concluido_a/b         : per-channel "message finished" pulses
// master : requesters and transmitter side (drives requests and tx_pronto)
// slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface arbitro_saida_serial_if;

    logic        pedido_a;
    logic [11:0] dados_a;
    logic        pedido_b;
    logic [11:0] dados_b;
    logic        tx_pronto;
    logic        tx_partida;
    logic [6:0]  tx_dados;
    logic        concluido_a;
    logic        concluido_b;

    modport master (
        output pedido_a, dados_a, pedido_b, dados_b, tx_pronto,
        input  tx_partida, tx_dados, concluido_a, concluido_b
    );

    modport slave (
        input  pedido_a, dados_a, pedido_b, dados_b, tx_pronto,
        output tx_partida, tx_dados, concluido_a, concluido_b
    );

endinterface

// File: rtl/arbitro_saida_serial_bcd_ascii.sv
// -----------------------------------------------------------------------------
// bcd_ascii
// Combinational BCD nibble to ASCII converter.
//   nibble : 4-bit input digit
//   ascii  : '0'..'9' for values 0..9, '?' for 10..15
// -----------------------------------------------------------------------------
module bcd_ascii
    import arbitro_saida_serial_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] ascii
);

    always_comb begin
        if (nibble <= 4'd9) begin
            ascii = ASCII_ZERO + {3'b000, nibble};
        end else begin
            ascii = ASCII_INTERROGACAO;
        end
    end

endmodule

// File: rtl/arbitro_saida_serial.sv
// -----------------------------------------------------------------------------
// arbitro_saida_serial
// Round-robin arbiter that serialises messages from two channels onto a single
// character transmitter. Each message is: channel ID, three BCD digits, then
// the SEPARADOR character, one character per tx_partida/tx_pronto exchange.
//   clock     : system clock (rising edge)
//   reset     : synchronous active-high reset
//   bus       : request / transmitter handshake (slave modport)
//   ocupado   : high whenever the FSM is not idle
//   db_estado : current state code for the debug display
// -----------------------------------------------------------------------------
module arbitro_saida_serial
    import arbitro_saida_serial_pkg::*;
#(
    parameter logic [6:0] SEPARADOR = 7'h23
) (
    input  logic                   clock,
    input  logic                   reset,
    arbitro_saida_serial_if.slave  bus,
    output logic                   ocupado,
    output logic [3:0]             db_estado
);

    estado_t     estado_reg,  estado_next;
    logic [2:0]  indice_reg,  indice_next;
    logic        canal_reg,   canal_next;
    logic [11:0] dados_reg,   dados_next;
    logic        ultimo_reg,  ultimo_next;

    logic        vencedor;
    logic [6:0]  digito_ascii [3];
    logic [6:0]  caractere;

    // ------------------------------------------------------------------
    // Arbitration: a lone request wins outright; on a tie the channel that
    // was not served last wins (CANAL_A/CANAL_B are 0/1, so invert).
    // ------------------------------------------------------------------
    always_comb begin
        if (bus.pedido_a && bus.pedido_b) begin
            vencedor = ~ultimo_reg;
        end else if (bus.pedido_b) begin
            vencedor = CANAL_B;
        end else begin
            vencedor = CANAL_A;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg <= ESPERA;
            indice_reg <= 3'd0;
            canal_reg  <= CANAL_A;
            dados_reg  <= 12'h000;
            ultimo_reg <= CANAL_B;
        end else begin
            estado_reg <= estado_next;
            indice_reg <= indice_next;
            canal_reg  <= canal_next;
            dados_reg  <= dados_next;
            ultimo_reg <= ultimo_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        estado_next = estado_reg;
        indice_next = indice_reg;
        canal_next  = canal_reg;
        dados_next  = dados_reg;
        ultimo_next = ultimo_reg;

        case (estado_reg)
            ESPERA: begin
                if (bus.pedido_a || bus.pedido_b) begin
                    estado_next = CARREGA;
                end
            end
            CARREGA: begin
                // Snapshot of the winner; the message is immune to later
                // changes on the request side.
                canal_next  = vencedor;
                dados_next  = (vencedor == CANAL_B) ? bus.dados_b : bus.dados_a;
                indice_next = 3'd0;
                estado_next = TRANSMITE;
            end
            TRANSMITE: begin
                estado_next = ESPERA_TX;
            end
            ESPERA_TX: begin
                if (bus.tx_pronto) begin
                    estado_next = PROXIMO;
                end
            end
            PROXIMO: begin
                if (indice_reg == INDICE_ULTIMO) begin
                    estado_next = FIM;
                end else begin
                    indice_next = indice_reg + 3'd1;
                    estado_next = TRANSMITE;
                end
            end
            FIM: begin
                ultimo_next = canal_reg;
                estado_next = ESPERA;
            end
            default: begin
                estado_next = ESPERA;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Character datapath: digit converters for [11:8], [7:4], [3:0]
    // (digito_ascii[2] is the most significant digit).
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digito
            bcd_ascii u_bcd_ascii (
                .nibble (dados_reg[4*gi +: 4]),
                .ascii  (digito_ascii[gi])
            );
        end
    endgenerate

    always_comb begin
        case (indice_reg)
            3'd0:    caractere = (canal_reg == CANAL_B) ? ASCII_B : ASCII_A;
            3'd1:    caractere = digito_ascii[2];
            3'd2:    caractere = digito_ascii[1];
            3'd3:    caractere = digito_ascii[0];
            3'd4:    caractere = SEPARADOR;
            default: caractere = 7'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore)
    // ------------------------------------------------------------------
    always_comb begin
        bus.tx_partida  = 1'b0;
        bus.concluido_a = 1'b0;
        bus.concluido_b = 1'b0;
        bus.tx_dados    = caractere;
        ocupado         = 1'b1;
        db_estado       = codigo_estado(estado_reg);

        case (estado_reg)
            ESPERA: begin
                ocupado      = 1'b0;
                bus.tx_dados = 7'h00;
            end
            TRANSMITE: begin
                bus.tx_partida = 1'b1;
            end
            FIM: begin
                bus.concluido_a = (canal_reg == CANAL_A);
                bus.concluido_b = (canal_reg == CANAL_B);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_arbitro_saida_serial.sv
// -----------------------------------------------------------------------------
// tb_arbitro_saida_serial
// Scoreboard bench: stimulus pushes expected characters/concluido events into
// a queue, a monitor pops and compares on every tx_partida or concluido pulse.
// A simple transmitter model answers each tx_partida with tx_pronto 10 cycles
// later.
// -----------------------------------------------------------------------------
module tb_arbitro_saida_serial;

    localparam int EV_CHAR  = 0;
    localparam int EV_CONCA = 1;
    localparam int EV_CONCB = 2;

    typedef struct {
        int         tipo;
        logic [6:0] valor;
    } evento_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ocupado;
    logic [3:0] db_estado;
    logic       pronto_modelo = 1'b0;
    logic       pronto_manual = 1'b0;
    int         tx_cnt = 0;
    int         n_partidas = 0;
    int         checks = 0;
    int         errors = 0;
    evento_t    fila [$];

    arbitro_saida_serial_if bus ();

    assign bus.tx_pronto = pronto_modelo | pronto_manual;

    arbitro_saida_serial #(
        .SEPARADOR (7'h23)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .ocupado   (ocupado),
        .db_estado (db_estado)
    );

    initial begin
        forever #5 clock = ~clock;
    end

    // Transmitter model
    initial begin
        forever begin
            @(negedge clock);
            pronto_modelo = 1'b0;
            if (reset) begin
                tx_cnt = 0;
            end else if (bus.tx_partida) begin
                tx_cnt = 10;
            end else if (tx_cnt > 0) begin
                tx_cnt = tx_cnt - 1;
                if (tx_cnt == 0) pronto_modelo = 1'b1;
            end
        end
    end

    task automatic verifica(input string nome, input int atual, input int esperado);
        checks = checks + 1;
        if (atual != esperado) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic compara_evento(input int tipo, input logic [6:0] valor);
        evento_t e;
        checks = checks + 1;
        if (fila.size() == 0) begin
            errors = errors + 1;
            $display("FAIL evento_inesperado: got tipo %0d valor %0h expected none", tipo, valor);
        end else begin
            e = fila.pop_front();
            if (e.tipo != tipo || e.valor != valor) begin
                errors = errors + 1;
                $display("FAIL evento: got tipo %0d valor %0h expected tipo %0d valor %0h",
                         tipo, valor, e.tipo, e.valor);
            end else begin
                $display("evento tipo %0d valor %0h ok", tipo, valor);
            end
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clock);
            if (bus.tx_partida) begin
                n_partidas = n_partidas + 1;
                compara_evento(EV_CHAR, bus.tx_dados);
            end
            if (bus.concluido_a) compara_evento(EV_CONCA, 7'h00);
            if (bus.concluido_b) compara_evento(EV_CONCB, 7'h00);
        end
    end

    task automatic empurra(input int tipo, input logic [6:0] valor);
        evento_t e;
        e.tipo  = tipo;
        e.valor = valor;
        fila.push_back(e);
    endtask

    // Full message with hand-computed digit characters.
    task automatic empurra_msg(input logic canal_b, input logic [6:0] c1,
                               input logic [6:0] c2, input logic [6:0] c3);
        empurra(EV_CHAR, canal_b ? 7'h42 : 7'h41);
        empurra(EV_CHAR, c1);
        empurra(EV_CHAR, c2);
        empurra(EV_CHAR, c3);
        empurra(EV_CHAR, 7'h23);
        empurra(canal_b ? EV_CONCB : EV_CONCA, 7'h00);
    endtask

    task automatic espera_conclusao(input logic canal_b, input string nome);
        bit visto = 0;
        for (int i = 0; i < 300 && !visto; i++) begin
            @(negedge clock);
            if (canal_b ? bus.concluido_b : bus.concluido_a) visto = 1;
        end
        if (!visto) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL timeout_%s: got no concluido expected pulse", nome);
        end
    endtask

    task automatic espera_ocioso(input string nome);
        bit livre = 0;
        for (int i = 0; i < 50 && !livre; i++) begin
            @(negedge clock);
            if (!ocupado) livre = 1;
        end
        verifica(nome, int'(livre), 1);
    endtask

    initial begin
        int base;
        bit chegou;
        bus.pedido_a = 1'b1;
        bus.pedido_b = 1'b1;
        bus.dados_a  = 12'h123;
        bus.dados_b  = 12'h907;

        // Reset state
        repeat (3) @(negedge clock);
        verifica("reset_ocupado", int'(ocupado), 0);
        verifica("reset_db_estado", int'(db_estado), 0);
        verifica("reset_tx_partida", int'(bus.tx_partida), 0);
        verifica("reset_tx_dados", int'(bus.tx_dados), 0);
        verifica("reset_concluido", int'({bus.concluido_a, bus.concluido_b}), 0);

        // Tie from reset: A first, then B
        empurra_msg(1'b0, 7'h31, 7'h32, 7'h33);
        empurra_msg(1'b1, 7'h39, 7'h30, 7'h37);
        reset = 1'b0;
        @(negedge clock);
        verifica("latencia_carrega", int'(db_estado), 1);
        @(negedge clock);
        verifica("latencia_transmite", int'(db_estado), 2);
        espera_conclusao(1'b0, "empate_a");
        bus.pedido_a = 1'b0;
        espera_conclusao(1'b1, "empate_b");
        bus.pedido_b = 1'b0;
        espera_ocioso("empate_ocioso");
        verifica("empate_fila", fila.size(), 0);

        // Single A message 123
        empurra_msg(1'b0, 7'h31, 7'h32, 7'h33);
        bus.pedido_a = 1'b1;
        espera_conclusao(1'b0, "a123");
        bus.pedido_a = 1'b0;
        repeat (3) @(negedge clock);
        verifica("a123_ocupado", int'(ocupado), 0);
        verifica("a123_fila", fila.size(), 0);

        // Non-decimal nibble
        bus.dados_a = 12'h1A5;
        empurra_msg(1'b0, 7'h31, 7'h3F, 7'h35);
        bus.pedido_a = 1'b1;
        espera_conclusao(1'b0, "a1a5");
        bus.pedido_a = 1'b0;
        espera_ocioso("a1a5_ocioso");

        // Payload changed after latching
        bus.dados_a = 12'h456;
        empurra_msg(1'b0, 7'h34, 7'h35, 7'h36);
        bus.pedido_a = 1'b1;
        repeat (2) @(negedge clock);
        bus.dados_a = 12'h999;
        espera_conclusao(1'b0, "a456");
        bus.pedido_a = 1'b0;
        espera_ocioso("a456_ocioso");

        // tx_pronto while idle
        pronto_manual = 1'b1;
        @(negedge clock);
        pronto_manual = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            verifica("pronto_ocioso_estado", int'(db_estado), 0);
            verifica("pronto_ocioso_partida", int'(bus.tx_partida), 0);
        end

        // Reset in the middle of a message
        bus.dados_a = 12'h123;
        base = n_partidas;
        empurra(EV_CHAR, 7'h41);
        empurra(EV_CHAR, 7'h31);
        empurra(EV_CHAR, 7'h32);
        bus.pedido_a = 1'b1;
        chegou = 0;
        for (int i = 0; i < 200 && !chegou; i++) begin
            @(negedge clock);
            if (n_partidas >= base + 3) chegou = 1;
        end
        verifica("aborto_tres_partidas", int'(chegou), 1);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        bus.pedido_a = 1'b0;
        @(negedge clock);
        verifica("aborto_estado", int'(db_estado), 0);
        verifica("aborto_partida", int'(bus.tx_partida), 0);
        verifica("aborto_ocupado", int'(ocupado), 0);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        verifica("aborto_fila", fila.size(), 0);
        empurra_msg(1'b0, 7'h31, 7'h32, 7'h33);
        bus.pedido_a = 1'b1;
        espera_conclusao(1'b0, "reinicio");
        bus.pedido_a = 1'b0;
        espera_ocioso("reinicio_ocioso");

        // B held high past concluido: served twice
        bus.dados_b = 12'h0F0;
        empurra_msg(1'b1, 7'h30, 7'h3F, 7'h30);
        empurra_msg(1'b1, 7'h30, 7'h3F, 7'h30);
        bus.pedido_b = 1'b1;
        espera_conclusao(1'b1, "b_primeira");
        espera_conclusao(1'b1, "b_segunda");
        bus.pedido_b = 1'b0;
        espera_ocioso("b_ocioso");
        verifica("fila_final", fila.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
